// File: rtl/uart_extin_loader_if.sv
// Write port from the serial loader into the pairing core's external input bank.
// The master drives one address/word pair with a single-cycle enable.
interface uart_extin_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 304
);
  logic [ADDR_W-1:0] extin_addr;
  logic [DATA_W-1:0] extin_data;
  logic              extin_en;

  modport master (
    output extin_addr,
    output extin_data,
    output extin_en
  );

  modport slave (
    input extin_addr,
    input extin_data,
    input extin_en
  );
endinterface

// File: rtl/uart_extin_loader.sv
// 8N1 UART frame loader: address byte + NBYTES data bytes -> one extin write.
// Define UART_EXTIN_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_extin_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 304,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_BITS = 200
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                uart_rx_i,
  uart_extin_loader_if.master ext,
  output logic                busy,
  output logic                frame_err,
  output logic                chk_err
);

  localparam int NBYTES = (DATA_W + 7) / 8;
  localparam int SH_W   = NBYTES * 8;
  localparam int BW     = $clog2(CLKS_PER_BIT);
  localparam int TO_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_LIM + 1);

  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bit_st_t;

  bit_st_t       st;
  logic          rx_q;
  logic          rx_s;
  logic          rx_d;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_sh;
  logic [7:0]    rx_byte;
  logic          byte_vld;

  logic              start_ok;
  logic              bit_idle;
  logic [5:0]        byte_cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [SH_W-1:0]   data_sh;
  logic [SH_W-1:0]   data_nxt;
  logic [TW-1:0]     to_cnt;
  logic              to_hit;

  // Bit receiver: mid-bit sampling of the synchronized line
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_q      <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      st        <= B_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      rx_sh     <= '0;
      rx_byte   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_q      <= uart_rx_i;
      rx_s      <= rx_q;
      rx_d      <= rx_s;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      unique case (st)
        B_IDLE: begin
          if (rx_d && !rx_s) begin
            baud_cnt <= HALF;
            st       <= B_START;
          end
        end
        B_START: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - BW'(1);
          end else if (!rx_s) begin
            baud_cnt <= FULL;
            bit_idx  <= '0;
            st       <= B_DATA;
          end else begin
            st <= B_IDLE;
          end
        end
        B_DATA: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - BW'(1);
          end else begin
            rx_sh    <= {rx_s, rx_sh[7:1]};
            baud_cnt <= FULL;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) st <= B_STOP;
          end
        end
        B_STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - BW'(1);
          end else begin
            if (rx_s) begin
              byte_vld <= 1'b1;
              rx_byte  <= rx_sh;
            end else begin
              frame_err <= 1'b1;
            end
            st <= B_IDLE;
          end
        end
        default: st <= B_IDLE;
      endcase
    end
  end

  assign start_ok = (st == B_START) && (baud_cnt == '0) && !rx_s;
  assign bit_idle = (st == B_IDLE);
  assign to_hit   = (byte_cnt != '0) && bit_idle &&
                    (to_cnt == TW'(TO_LIM - 1));

  // Data bytes arrive LSB first, so shifting down lands byte 1 at bit 0
  assign data_nxt = {rx_byte, data_sh[SH_W-1:8]};

`ifdef UART_EXTIN_LOADER_CHECKSUM_EN
  logic [7:0] xor_acc;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt       <= '0;
      addr_sh        <= '0;
      data_sh        <= '0;
      to_cnt         <= '0;
      busy           <= 1'b0;
      ext.extin_en   <= 1'b0;
      ext.extin_addr <= '0;
      ext.extin_data <= '0;
`ifdef UART_EXTIN_LOADER_CHECKSUM_EN
      chk_err        <= 1'b0;
      xor_acc        <= '0;
`endif
    end else begin
      ext.extin_en <= 1'b0;
`ifdef UART_EXTIN_LOADER_CHECKSUM_EN
      chk_err      <= 1'b0;
`endif
      if (byte_cnt != '0 && bit_idle) to_cnt <= to_cnt + TW'(1);
      else                            to_cnt <= '0;
      if (start_ok && byte_cnt == '0) busy <= 1'b1;

      if (frame_err || to_hit) begin
        byte_cnt <= '0;
        busy     <= 1'b0;
        to_cnt   <= '0;
      end else if (byte_vld) begin
        if (byte_cnt == '0) begin
          addr_sh  <= ADDR_W'(rx_byte);
          byte_cnt <= 6'd1;
`ifdef UART_EXTIN_LOADER_CHECKSUM_EN
          xor_acc  <= rx_byte;
`endif
        end else if (byte_cnt <= 6'(NBYTES)) begin
          data_sh  <= data_nxt;
          byte_cnt <= byte_cnt + 6'd1;
`ifdef UART_EXTIN_LOADER_CHECKSUM_EN
          xor_acc  <= xor_acc ^ rx_byte;
`else
          if (byte_cnt == 6'(NBYTES)) begin
            ext.extin_addr <= addr_sh;
            ext.extin_data <= data_nxt[DATA_W-1:0];
            ext.extin_en   <= 1'b1;
            busy           <= 1'b0;
            byte_cnt       <= '0;
          end
`endif
        end
`ifdef UART_EXTIN_LOADER_CHECKSUM_EN
        else begin
          byte_cnt <= '0;
          busy     <= 1'b0;
          if (rx_byte == xor_acc) begin
            ext.extin_addr <= addr_sh;
            ext.extin_data <= data_sh[DATA_W-1:0];
            ext.extin_en   <= 1'b1;
          end else begin
            chk_err <= 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_extin_loader.sv
// Directed/randomized bench for uart_extin_loader at 16 clocks per bit.
// Frames are modelled as byte lists; expected words are built from those lists.
module tb_uart_extin_loader;

  localparam int CPB = 16;
  localparam int DW  = 304;
  localparam int AW  = 8;
  localparam int TOB = 200;
  localparam int NB  = 38;
`ifdef UART_EXTIN_LOADER_CHECKSUM_EN
  localparam int FL = NB + 2;
`else
  localparam int FL = NB + 1;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rx   = 1'b1;
  logic busy;
  logic frame_err;
  logic chk_err;

  uart_extin_loader_if #(.ADDR_W(AW), .DATA_W(DW)) ext ();

  uart_extin_loader #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .uart_rx_i(rx),
    .ext      (ext.master),
    .busy     (busy),
    .frame_err(frame_err),
    .chk_err  (chk_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int fe_cnt = 0;
  int ce_cnt = 0;
  int en_cyc = 0;
  logic [AW-1:0] got_addr = '0;
  logic [DW-1:0] got_data = '0;

  always @(negedge clk) begin
    if (ext.extin_en === 1'b1) begin
      en_cnt   = en_cnt + 1;
      en_cyc   = cyc;
      got_addr = ext.extin_addr;
      got_data = ext.extin_data;
    end
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (chk_err === 1'b1)   ce_cnt = ce_cnt + 1;
  end

  logic [7:0] fq[$];
  int last_start;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called aligned at posedge+1; returns aligned, so bytes abut with no gap
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic send_range(input int lo, input int hi, input int bad);
    for (int i = lo; i <= hi; i++) send_byte(fq[i], i != bad);
  endtask

  // Appends one frame to fq and returns the word it should commit
  task automatic build(input logic [7:0] a, input bit rnd, input bit bad_chk,
                       output logic [DW-1:0] word);
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] ck;
    fq.push_back(a);
    x = a;
    word = '0;
    for (int i = 0; i < NB; i++) begin
      b = rnd ? 8'($urandom) : 8'(i + 1);
      fq.push_back(b);
      x = x ^ b;
      word[8*i +: 8] = b;
    end
    ck = bad_chk ? (x ^ 8'h01) : x;
`ifdef UART_EXTIN_LOADER_CHECKSUM_EN
    fq.push_back(ck);
`else
    if (ck == 8'h00) word = word;
`endif
  endtask

  initial begin
    int en0;
    int fe0;
    int ce0;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic [7:0] a;

    // T1 reset with line toggling
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 rx = ~rx;
    end
    rx = 1'b1;
    tick(1);
    check("rst_en", ext.extin_en, 0);
    check("rst_addr", ext.extin_addr, 0);
    check("rst_data", ext.extin_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_cerr", chk_err, 0);
    rstn = 1'b1;
    en0 = en_cnt;
    tick(50);
    check("rst_no_en", en_cnt - en0, 0);

    // T2 nominal frame
    fq.delete();
    build(8'h85, 0, 0, e1);
    en0 = en_cnt;
    send_range(0, 19, -1);
    check("t2_busy_mid", busy, 1);
    send_range(20, FL - 1, -1);
    tick(5);
    check("t2_en_cnt", en_cnt - en0, 1);
    check("t2_addr", got_addr, 8'h85);
    check("t2_data", got_data, e1);
    check("t2_lsb", got_data[7:0], 8'h01);
    check("t2_msb", got_data[303:296], 8'h26);
    check("t2_timing", en_cyc, last_start + 156);
    check("t2_busy_end", busy, 0);

    // T3 framing error on byte 5, then a good frame at 0x10
    fq.delete();
    build(8'h33, 1, 0, e2);
    en0 = en_cnt;
    fe0 = fe_cnt;
    send_range(0, 5, 5);
    tick(40);
    check("t3_ferr", fe_cnt - fe0, 1);
    check("t3_no_en", en_cnt - en0, 0);
    check("t3_busy", busy, 0);
    fq.delete();
    build(8'h10, 1, 0, e2);
    send_range(0, FL - 2, -1);
    check("t3_hold_addr", ext.extin_addr, 8'h85);
    check("t3_hold_data", ext.extin_data, e1);
    send_range(FL - 1, FL - 1, -1);
    tick(5);
    check("t3_en_cnt", en_cnt - en0, 1);
    check("t3_addr", got_addr, 8'h10);
    check("t3_data", got_data, e2);

    // T4 glitch, then timeout of a partial frame, then a good frame
    en0 = en_cnt;
    fe0 = fe_cnt;
    ce0 = ce_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    check("t4_glitch_busy", busy, 0);
    a = 8'($urandom);
    fq.delete();
    build(a, 1, 0, e1);
    send_range(0, 10, -1);
    tick(TOB * CPB - 100);
    check("t4_busy_pre", busy, 1);
    tick(150);
    check("t4_busy_post", busy, 0);
    check("t4_no_en", en_cnt - en0, 0);
    check("t4_no_fe", fe_cnt - fe0, 0);
    check("t4_no_ce", ce_cnt - ce0, 0);
    check("t4_hold_data", ext.extin_data, e2);
    fq.delete();
    build(a ^ 8'h5C, 1, 0, e1);
    send_range(0, FL - 1, -1);
    tick(5);
    check("t4_en_cnt", en_cnt - en0, 1);
    check("t4_addr", got_addr, a ^ 8'h5C);
    check("t4_data", got_data, e1);

    // T5 back-to-back frames
    fq.delete();
    build(8'h01, 1, 0, e1);
    build(8'h02, 1, 0, e2);
    en0 = en_cnt;
    send_range(0, FL + 19, -1);
    check("t5_first_en", en_cnt - en0, 1);
    check("t5_hold_addr", ext.extin_addr, 8'h01);
    check("t5_hold_data", ext.extin_data, e1);
    send_range(FL + 20, 2 * FL - 1, -1);
    tick(5);
    check("t5_en_cnt", en_cnt - en0, 2);
    check("t5_addr", got_addr, 8'h02);
    check("t5_data", got_data, e2);

`ifdef UART_EXTIN_LOADER_CHECKSUM_EN
    // T6 checksum accept and reject
    fq.delete();
    build(8'hA5, 1, 0, e1);
    en0 = en_cnt;
    ce0 = ce_cnt;
    send_range(0, FL - 1, -1);
    tick(5);
    check("t6_good_en", en_cnt - en0, 1);
    check("t6_good_data", got_data, e1);
    fq.delete();
    build(8'h5A, 1, 1, e2);
    send_range(0, FL - 1, -1);
    tick(5);
    check("t6_bad_ce", ce_cnt - ce0, 1);
    check("t6_bad_no_en", en_cnt - en0, 1);
    check("t6_bad_addr", ext.extin_addr, 8'hA5);
    check("t6_bad_data", ext.extin_data, e1);
    check("t6_bad_busy", busy, 0);
`else
    check("no_chk_err", ce_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
